// File: rtl/fismos_mem_arbiter_pkg.sv
// Shared fismos definitions: arbiter state encoding, forced-completion pattern,
// timeout defaults and the core control register address.
package fismos_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] FISMOS_TIMEOUT_PATTERN          = 32'hDEAD_BEEF;
  localparam int unsigned FISMOS_TIMEOUT_CYCLES_DEFAULT   = 32'd255;
  localparam int unsigned FISMOS_TIMEOUT_CNT_W            = 32'd16;
  localparam logic [31:0] FISMOS_CONTROL_REGISTER_ADDRESS = 32'h0200_0000;

  function automatic logic [1:0] grant_onehot(input arb_state_e state);
    case (state)
      ARB_GRANT0: return 2'b01;
      ARB_GRANT1: return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/fismos_mem_arbiter_rr_pick.sv
// Two-way round-robin select: on a tie the requester that did not win last
// time is picked; a single requester is always picked.
module fismos_rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic pick_valid_o,
  output logic pick_o
);

  // Select the winner among the currently valid requesters
  always_comb begin
    pick_valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      pick_o = ~last_grant_i;
    end else if (req1_i) begin
      pick_o = 1'b1;
    end else begin
      pick_o = 1'b0;
    end
  end

endmodule

// File: rtl/fismos_mem_arbiter.sv
// Two-requester native memory arbiter in front of the AXI adapter.
// Optional forced completion of stalled grants: define FISMOS_ARB_TIMEOUT_EN.
module fismos_mem_arbiter
  import fismos_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = FISMOS_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,

  input  logic        s0_mem_valid,
  input  logic        s0_mem_instr,
  input  logic [31:0] s0_mem_addr,
  input  logic [31:0] s0_mem_wdata,
  input  logic [3:0]  s0_mem_wstrb,
  output logic        s0_mem_ready,
  output logic [31:0] s0_mem_rdata,

  input  logic        s1_mem_valid,
  input  logic        s1_mem_instr,
  input  logic [31:0] s1_mem_addr,
  input  logic [31:0] s1_mem_wdata,
  input  logic [3:0]  s1_mem_wstrb,
  output logic        s1_mem_ready,
  output logic [31:0] s1_mem_rdata,

  output logic        m_mem_valid,
  output logic        m_mem_instr,
  output logic [31:0] m_mem_addr,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic        m_mem_ready,
  input  logic [31:0] m_mem_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        pick_valid_s, pick_s;
  logic        timeout_hit_s;

  logic        sel1_s;
  logic        sel_valid_s;
  logic        sel_instr_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_wstrb_s;

  // The counter is 16 bits wide; larger limits would never be reached
  if (TIMEOUT_CYCLES > 32'd65535) begin : g_timeout_out_of_range
  end

  fismos_rr_pick u_rr_pick (
    .req0_i       (s0_mem_valid),
    .req1_i       (s1_mem_valid),
    .last_grant_i (last_grant_q),
    .pick_valid_o (pick_valid_s),
    .pick_o       (pick_s)
  );

  assign sel1_s      = (state_q == ARB_GRANT1);
  assign sel_valid_s = sel1_s ? s1_mem_valid : s0_mem_valid;
  assign sel_instr_s = sel1_s ? s1_mem_instr : s0_mem_instr;
  assign sel_addr_s  = sel1_s ? s1_mem_addr  : s0_mem_addr;
  assign sel_wdata_s = sel1_s ? s1_mem_wdata : s0_mem_wdata;
  assign sel_wstrb_s = sel1_s ? s1_mem_wstrb : s0_mem_wstrb;

  assign grant = grant_onehot(state_q);

`ifdef FISMOS_ARB_TIMEOUT_EN
  localparam logic [FISMOS_TIMEOUT_CNT_W-1:0] TIMEOUT_LIMIT =
    FISMOS_TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

  logic [FISMOS_TIMEOUT_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                            timeout_err_q, timeout_err_d;

  // Only a still-valid owner is force-completed; an aborted grant just ends
  assign timeout_hit_s = (state_q != ARB_IDLE) && sel_valid_s && (tmo_cnt_q == TIMEOUT_LIMIT);

  // Stall counter and sticky error next state
  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q | timeout_hit_s;
    if (state_q == ARB_IDLE) begin
      tmo_cnt_d = '0;
    end else if (!m_mem_ready) begin
      tmo_cnt_d = tmo_cnt_q + FISMOS_TIMEOUT_CNT_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Stall counter and sticky error registers
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // Arbitration next state and request/response routing
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_mem_valid  = 1'b0;
    m_mem_instr  = 1'b0;
    m_mem_addr   = 32'h0000_0000;
    m_mem_wdata  = 32'h0000_0000;
    m_mem_wstrb  = 4'h0;
    s0_mem_ready = 1'b0;
    s0_mem_rdata = 32'h0000_0000;
    s1_mem_ready = 1'b0;
    s1_mem_rdata = 32'h0000_0000;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          state_d = pick_s ? ARB_GRANT1 : ARB_GRANT0;
        end else begin
          state_d = ARB_IDLE;
        end
      end

      ARB_GRANT0, ARB_GRANT1: begin
        if (timeout_hit_s) begin
          state_d      = ARB_IDLE;
          last_grant_d = sel1_s;
          if (sel1_s) begin
            s1_mem_ready = 1'b1;
            s1_mem_rdata = FISMOS_TIMEOUT_PATTERN;
          end else begin
            s0_mem_ready = 1'b1;
            s0_mem_rdata = FISMOS_TIMEOUT_PATTERN;
          end
        end else begin
          m_mem_valid = sel_valid_s;
          m_mem_instr = sel_instr_s;
          m_mem_addr  = sel_addr_s;
          m_mem_wdata = sel_wdata_s;
          m_mem_wstrb = sel_wstrb_s;
          // Gate with valid so an aborting owner never sees a completion
          if (sel1_s) begin
            s1_mem_ready = m_mem_ready & s1_mem_valid;
            s1_mem_rdata = m_mem_rdata;
          end else begin
            s0_mem_ready = m_mem_ready & s0_mem_valid;
            s0_mem_rdata = m_mem_rdata;
          end
          if (!sel_valid_s) begin
            state_d = ARB_IDLE;
          end else if (m_mem_ready) begin
            state_d      = ARB_IDLE;
            last_grant_d = sel1_s;
          end else begin
            state_d = state_q;
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Arbitration state and fairness history
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_fismos_mem_arbiter.sv
// Directed self-checking bench for fismos_mem_arbiter; inputs change on the
// falling edge and outputs are sampled 1 ns later.
module tb_fismos_mem_arbiter;

  logic        clk;
  logic        rstn;
  logic        s0_valid, s0_instr, s0_ready;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic        s1_valid, s1_instr, s1_ready;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic        m_valid, m_instr, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  logic seen_ready;
  logic [1:0] fair_seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] fair_addr [6] = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h100, 32'h200};

  fismos_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rstn),
    .s0_mem_valid  (s0_valid),
    .s0_mem_instr  (s0_instr),
    .s0_mem_addr   (s0_addr),
    .s0_mem_wdata  (s0_wdata),
    .s0_mem_wstrb  (s0_wstrb),
    .s0_mem_ready  (s0_ready),
    .s0_mem_rdata  (s0_rdata),
    .s1_mem_valid  (s1_valid),
    .s1_mem_instr  (s1_instr),
    .s1_mem_addr   (s1_addr),
    .s1_mem_wdata  (s1_wdata),
    .s1_mem_wstrb  (s1_wstrb),
    .s1_mem_ready  (s1_ready),
    .s1_mem_rdata  (s1_rdata),
    .m_mem_valid   (m_valid),
    .m_mem_instr   (m_instr),
    .m_mem_addr    (m_addr),
    .m_mem_wdata   (m_wdata),
    .m_mem_wstrb   (m_wstrb),
    .m_mem_ready   (m_ready),
    .m_mem_rdata   (m_rdata),
    .grant         (grant),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    s0_valid = 1'b0; s0_instr = 1'b0; s0_addr = 32'h0; s0_wdata = 32'h0; s0_wstrb = 4'h0;
    s1_valid = 1'b0; s1_instr = 1'b0; s1_addr = 32'h0; s1_wdata = 32'h0; s1_wstrb = 4'h0;
    m_ready = 1'b0; m_rdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("rst_s1_ready", {31'd0, s1_ready}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rstn = 1'b1;

    // Single s0 read, slave answers on the third grant cycle
    @(negedge clk);
    s0_valid = 1'b1; s0_instr = 1'b1; s0_addr = 32'h10; s0_wstrb = 4'h0;
    #1;
    chk("rd_first_cycle_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rd_first_cycle_grant", {30'd0, grant}, 32'd0);
    @(negedge clk); #1;
    chk("rd_grant", {30'd0, grant}, 32'd1);
    chk("rd_m_valid", {31'd0, m_valid}, 32'd1);
    chk("rd_m_addr", m_addr, 32'h10);
    chk("rd_m_instr", {31'd0, m_instr}, 32'd1);
    chk("rd_m_wstrb", {28'd0, m_wstrb}, 32'd0);
    chk("rd_wait_s0_ready", {31'd0, s0_ready}, 32'd0);
    @(negedge clk); #1;
    chk("rd_wait_m_valid", {31'd0, m_valid}, 32'd1);
    @(negedge clk);
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    chk("rd_s0_ready", {31'd0, s0_ready}, 32'd1);
    chk("rd_s0_rdata", s0_rdata, 32'h1234_5678);
    chk("rd_s1_ready", {31'd0, s1_ready}, 32'd0);
    chk("rd_s1_rdata", s1_rdata, 32'd0);
    @(negedge clk);
    m_ready = 1'b0; m_rdata = 32'h0; s0_valid = 1'b0; s0_instr = 1'b0;
    #1;
    chk("rd_done_grant", {30'd0, grant}, 32'd0);
    chk("rd_done_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rd_done_s0_ready", {31'd0, s0_ready}, 32'd0);

    // Simultaneous requests after reset: s0 first, one idle cycle, then s1
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 32'h100;
    s1_valid = 1'b1; s1_addr = 32'h200; s1_wstrb = 4'h3; s1_wdata = 32'h0000_55AA;
    @(negedge clk); #1;
    chk("tie_first_grant", {30'd0, grant}, 32'd1);
    chk("tie_first_addr", m_addr, 32'h100);
    m_ready = 1'b1; m_rdata = 32'hA5A5_0001;
    #1;
    chk("tie_s0_ready", {31'd0, s0_ready}, 32'd1);
    chk("tie_s0_rdata", s0_rdata, 32'hA5A5_0001);
    chk("tie_s1_ready_held", {31'd0, s1_ready}, 32'd0);
    chk("tie_s1_rdata_held", s1_rdata, 32'd0);
    @(negedge clk);
    m_ready = 1'b0; m_rdata = 32'h0; s0_valid = 1'b0;
    #1;
    chk("tie_gap_m_valid", {31'd0, m_valid}, 32'd0);
    chk("tie_gap_grant", {30'd0, grant}, 32'd0);
    @(negedge clk); #1;
    chk("tie_second_grant", {30'd0, grant}, 32'd2);
    chk("tie_second_addr", m_addr, 32'h200);
    chk("tie_second_wstrb", {28'd0, m_wstrb}, 32'd3);
    chk("tie_second_wdata", m_wdata, 32'h0000_55AA);
    m_ready = 1'b1;
    #1;
    chk("tie_s1_ready", {31'd0, s1_ready}, 32'd1);
    chk("tie_s0_ready_idle", {31'd0, s0_ready}, 32'd0);
    @(negedge clk);
    m_ready = 1'b0; s1_valid = 1'b0; s1_wstrb = 4'h0;
    #1;
    chk("tie_done_grant", {30'd0, grant}, 32'd0);

    // Both continuously valid: six alternating grants
    @(negedge clk);
    s0_valid = 1'b1; s1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk($sformatf("fair_grant_%0d", i), {30'd0, grant}, {30'd0, fair_seq[i]});
      chk($sformatf("fair_addr_%0d", i), m_addr, fair_addr[i]);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      if (i == 5) begin
        s0_valid = 1'b0; s1_valid = 1'b0;
      end
      #1;
      chk($sformatf("fair_gap_%0d", i), {31'd0, m_valid}, 32'd0);
    end

    // s1 aborts while s0 waits: no ready pulse, s0 served next
    @(negedge clk);
    s1_valid = 1'b1; s1_addr = 32'h300;
    @(negedge clk);
    s0_valid = 1'b1;
    #1;
    chk("abort_grant1", {30'd0, grant}, 32'd2);
    chk("abort_grant1_addr", m_addr, 32'h300);
    @(negedge clk);
    s1_valid = 1'b0;
    #1;
    chk("abort_m_valid", {31'd0, m_valid}, 32'd0);
    chk("abort_s1_ready", {31'd0, s1_ready}, 32'd0);
    @(negedge clk); #1;
    chk("abort_idle_grant", {30'd0, grant}, 32'd0);
    chk("abort_idle_s1_ready", {31'd0, s1_ready}, 32'd0);
    @(negedge clk); #1;
    chk("abort_s0_next", {30'd0, grant}, 32'd1);
    chk("abort_s0_addr", m_addr, 32'h100);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0; s0_valid = 1'b0;
    #1;
    chk("abort_s0_done", {30'd0, grant}, 32'd0);

    // Abort leaves history alone: s0 won last, so s1 wins the next tie
    @(negedge clk);
    s1_valid = 1'b1;
    @(negedge clk);
    s1_valid = 1'b0;
    #1;
    chk("abort2_grant1", {30'd0, grant}, 32'd2);
    @(negedge clk);
    s0_valid = 1'b1; s1_valid = 1'b1; s1_wstrb = 4'hF; s1_wdata = 32'hCAFE_F00D;
    #1;
    chk("abort2_idle", {30'd0, grant}, 32'd0);
    @(negedge clk); #1;
    chk("abort_keeps_last", {30'd0, grant}, 32'd2);
    chk("wr_m_wstrb", {28'd0, m_wstrb}, 32'hF);
    chk("wr_m_wdata", m_wdata, 32'hCAFE_F00D);

    // Reset in the middle of the s1 write
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk); #1;
    chk("midrst_grant", {30'd0, grant}, 32'd0);
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_s1_ready", {31'd0, s1_ready}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_s0_tie_win", {30'd0, grant}, 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; s1_wstrb = 4'h0;

    // Slave never answers
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 32'h40;
    seen_ready = 1'b0;
`ifdef FISMOS_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (s0_ready) seen_ready = 1'b1;
    end
    chk("tmo_no_early_ready", {31'd0, seen_ready}, 32'd0);
    @(negedge clk); #1;
    chk("tmo_s0_ready", {31'd0, s0_ready}, 32'd1);
    chk("tmo_s0_rdata", s0_rdata, 32'hDEAD_BEEF);
    chk("tmo_m_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    s0_valid = 1'b0;
    #1;
    chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
    chk("tmo_idle", {30'd0, grant}, 32'd0);
    @(negedge clk); #1;
    chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (s0_ready) seen_ready = 1'b1;
    end
    chk("stall_no_ready", {31'd0, seen_ready}, 32'd0);
    chk("stall_grant_held", {30'd0, grant}, 32'd1);
    chk("stall_no_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    s0_valid = 1'b0;
    @(negedge clk); #1;
    chk("stall_abort_idle", {30'd0, grant}, 32'd0);
`endif

    // Reset clears the error flag
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk); #1;
    chk("final_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("final_rst_grant", {30'd0, grant}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
